// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM state encoding and constants for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ITER = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  // Quotient reported for any divide by zero
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation: y = neg ? -x : x.
module cond_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~x + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// Works on magnitudes (shift-add multiply, restoring divide, one bit per cycle)
// and applies the result signs in a single FIX cycle.
module muldiv_unit #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [1:0]  Op,
  input  logic        Signed,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  import muldiv_pkg::*;

  localparam int CW = $clog2(ITER + 1);

  state_e          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic [31:0]     r_hi, r_lo;
  // MUL: {partial product, remaining multiplier bits}; DIV: {remainder, dividend/quotient bits}
  logic [63:0]     r_acc;
  logic [31:0]     r_opnd;
  logic            r_is_div, r_sign_q, r_sign_r, r_div0;

  logic            w_idle, w_accept, w_mthi, w_mtlo, w_last;
  logic [31:0]     w_mag_a, w_mag_b, w_quot, w_rem;
  logic [32:0]     w_sum, w_trial;
  logic [63:0]     w_mul_step, w_div_step, w_prod;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_accept = w_idle && Start && ((Op == OP_MULT) || (Op == OP_DIV));
  assign w_mthi   = w_idle && Start && (Op == OP_MTHI);
  assign w_mtlo   = w_idle && Start && (Op == OP_MTLO);
  assign w_last   = (r_cnt == CW'(ITER - 1));

  cond_negate #(.W(32)) u_mag_a (.x(A), .neg(Signed & A[31]), .y(w_mag_a));
  cond_negate #(.W(32)) u_mag_b (.x(B), .neg(Signed & B[31]), .y(w_mag_b));
  cond_negate #(.W(64)) u_prod  (.x(r_acc), .neg(r_sign_q), .y(w_prod));
  cond_negate #(.W(32)) u_quot  (.x(r_acc[31:0]), .neg(r_sign_q), .y(w_quot));
  cond_negate #(.W(32)) u_rem   (.x(r_acc[63:32]), .neg(r_sign_r), .y(w_rem));

  // Shift-add: add multiplicand when the current multiplier LSB is set, then shift right
  assign w_sum      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_step = {w_sum, r_acc[31:1]};

  // Restoring divide: {rem, next dividend bit} always fits 33 bits, so bit 32 is the sign
  assign w_trial    = {r_acc[63:32], r_acc[31]} - {1'b0, r_opnd};
  assign w_div_step = w_trial[32] ? {r_acc[62:0], 1'b0}
                                  : {w_trial[31:0], r_acc[30:0], 1'b1};

  assign Busy = !w_idle;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

  // Next-state logic: IDLE -> ITER on accept, ITER -> FIX after the last iteration
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_ITER;
      ST_ITER: if (w_last)   w_state_nxt = ST_FIX;
      ST_FIX:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, iteration counter and Done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == ST_FIX);
      if (w_accept)
        r_cnt <= '0;
      else if (r_state == ST_ITER)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  // Architectural HI/LO: written by FIX or by MTHI/MTLO, held otherwise
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == ST_FIX) begin
      if (r_is_div) begin
        r_hi <= w_rem;
        r_lo <= r_div0 ? DIV0_QUOT : w_quot;
      end else begin
        r_hi <= w_prod[63:32];
        r_lo <= w_prod[31:0];
      end
    end else if (w_mthi) begin
      r_hi <= A;
    end else if (w_mtlo) begin
      r_lo <= A;
    end
  end

  // Datapath: latch magnitudes and signs on accept, then iterate one bit per cycle
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_is_div <= (Op == OP_DIV);
      r_sign_q <= Signed & (A[31] ^ B[31]);
      r_sign_r <= Signed & A[31];
      r_div0   <= (B == 32'd0);
      if (Op == OP_DIV) begin
        r_acc  <= {32'd0, w_mag_a};
        r_opnd <= w_mag_b;
      end else begin
        r_acc  <= {32'd0, w_mag_b};
        r_opnd <= w_mag_a;
      end
    end else if (r_state == ST_ITER) begin
      r_acc <= r_is_div ? w_div_step : w_mul_step;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: multiply/divide results, latency, MT ops,
// busy-time Start rejection, mid-operation reset and back-to-back issue.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [1:0]  Op;
  logic        Signed, Start;
  logic        Busy, Done;
  logic [31:0] HI, LO;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi, m_lo;
  int          cyc, busy_cnt;
  logic        hold_bad;

  always #5 clk = ~clk;

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .Op(Op), .Signed(Signed),
    .Start(Start), .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge
  task automatic start_op(input logic [1:0] op, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b);
    Op = op; Signed = sgn; A = a; B = b; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  // Counts negedges until Done, tracking Busy and any early HI/LO change
  task automatic wait_done();
    cyc = 0; busy_cnt = 0; hold_bad = 1'b0;
    while (Done !== 1'b1 && cyc < 200) begin
      if (Busy === 1'b1) busy_cnt++;
      if (HI !== m_hi || LO !== m_lo) hold_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic mdop(input string tag, input logic [1:0] op, input logic sgn,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ehi, input logic [31:0] elo);
    start_op(op, sgn, a, b);
    wait_done();
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({tag, " hold"}, {63'd0, hold_bad}, 64'd0);
    check({tag, " busy_in_done"}, {63'd0, Busy}, 64'd0);
    check({tag, " HI"}, {32'd0, HI}, {32'd0, ehi});
    check({tag, " LO"}, {32'd0, LO}, {32'd0, elo});
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    reset = 1'b0; A = '0; B = '0; Op = 2'b00; Signed = 1'b0; Start = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset Busy", {63'd0, Busy}, 64'd0);
    check("reset Done", {63'd0, Done}, 64'd0);
    check("reset HI", {32'd0, HI}, 64'd0);
    check("reset LO", {32'd0, LO}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Multiplies
    mdop("multu_max", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(negedge clk);
    check("done_single_pulse", {63'd0, Done}, 64'd0);
    mdop("mult_m3x7", 2'b00, 1'b1, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    mdop("mult_minsq", 2'b00, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

    // Divides
    mdop("div_m7d2", 2'b01, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    mdop("divu_100d7", 2'b01, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    mdop("div0_signed", 2'b01, 1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    mdop("div0_unsigned", 2'b01, 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);
    mdop("div_ovf", 2'b01, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // MTHI in IDLE: visible next cycle, no Busy, no Done
    start_op(2'b10, 1'b0, 32'hAAAA_5555, 32'd0);
    check("mthi HI", {32'd0, HI}, {32'd0, 32'hAAAA_5555});
    check("mthi LO", {32'd0, LO}, {32'd0, m_lo});
    check("mthi Busy", {63'd0, Busy}, 64'd0);
    check("mthi Done", {63'd0, Done}, 64'd0);
    m_hi = 32'hAAAA_5555;

    // Start of MTLO and MULT while busy must be ignored
    start_op(2'b00, 1'b0, 32'd3, 32'd4);
    repeat (3) @(negedge clk);
    Op = 2'b11; A = 32'hDEAD_BEEF; Start = 1'b1;
    @(negedge clk);
    check("busy_mtlo LO", {32'd0, LO}, {32'd0, m_lo});
    Op = 2'b00; A = 32'd1000; B = 32'd1000; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    wait_done();
    check("busy_ign latency", 64'(cyc), 64'd28);
    check("busy_ign hold", {63'd0, hold_bad}, 64'd0);
    check("busy_ign HI", {32'd0, HI}, 64'd0);
    check("busy_ign LO", {32'd0, LO}, 64'd12);
    m_hi = 32'd0; m_lo = 32'd12;

    // Reset part-way through a divide
    start_op(2'b01, 1'b0, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset Busy", {63'd0, Busy}, 64'd0);
    check("midreset Done", {63'd0, Done}, 64'd0);
    check("midreset HI", {32'd0, HI}, 64'd0);
    check("midreset LO", {32'd0, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    @(negedge clk);
    mdop("mult_5x6", 2'b00, 1'b0, 32'd5, 32'd6, 32'd0, 32'd30);

    // Back-to-back: new Start issued in the Done cycle
    mdop("b2b_first", 2'b01, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    check("b2b done_seen", {63'd0, Done}, 64'd1);
    mdop("b2b_second", 2'b00, 1'b0, 32'd9, 32'd9, 32'd0, 32'd81);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the EX stage. It takes the same operand pair (`A`, `B`) and `Signed` flag that the EX-stage adder/subtracter receives. It computes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO registers, which it holds for MFHI/MFLO. It also executes MTHI/MTLO in one cycle. Pipeline control stalls on `Busy`.

## Interface

Parameters:
- `ITER`, default 32: iteration cycles per operation. Fixed at 32 for the 32-bit datapath; the parameter exists only for shortened test builds.

Ports:
- `clk`: in, 1. Single clock; all state updates on the rising edge.
- `reset`: in, 1. Asynchronous, active-low.
- `A`: in, 32. Multiplicand, dividend, or MTHI/MTLO source.
- `B`: in, 32. Multiplier or divisor.
- `Op`: in, 2. Operation select: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `Signed`: in, 1. 1 selects two's-complement; 0 selects unsigned. Ignored for MTHI/MTLO.
- `Start`: in, 1. Request; sampled only in IDLE.
- `Busy`: out, 1. High while MUL/DIV is in progress.
- `Done`: out, 1. One-cycle pulse when new HI/LO from MUL/DIV are visible.
- `HI`: out, 32. HI register.
- `LO`: out, 32. LO register.

## Operation

- Reset (asynchronous, active-low): state IDLE, `Busy`=0, `Done`=0, `HI`=`LO`=0, iteration counter=0. Reset mid-operation aborts the operation and discards partial results.
- States:
  - IDLE to ITER on `Start` with `Op`=00/01.
  - ITER to FIX after `ITER` iterations.
  - FIX to IDLE unconditionally.
- MTHI/MTLO (`Start`=1 in IDLE): `HI` or `LO` takes `A` at that edge. The other register is unchanged, no `Busy`, no `Done`.
- `Start` in ITER/FIX is ignored entirely, including MT ops. The pipeline is responsible for stalling.
- On accept: latch magnitudes `|A|`, `|B|` (raw values when `Signed`=0), `Op`, and the result signs:
  - product sign = `A[31]`^`B[31]`
  - quotient sign = `A[31]`^`B[31]`
  - remainder sign = `A[31]`
  - All signs are forced to 0 when `Signed`=0.
- MUL: shift-add, one multiplier bit per cycle, 64-bit accumulator.
- DIV: restoring division, one quotient bit per cycle:
  - 33-bit trial subtract of the divisor from {partial remainder, next dividend bit}.
  - On non-negative result, keep it and set the quotient bit to 1.
- FIX: apply conditional two's-complement negation to the product (64-bit) or to the quotient and remainder separately. Write `HI`/`LO`:
  - MUL: `HI` = product[63:32], `LO` = product[31:0].
  - DIV: `LO` = quotient, `HI` = remainder.
- Divide by zero gives a defined result:
  - `LO` = 0xFFFFFFFF, `HI` = `A`, in both signed and unsigned modes.
  - Still takes the full latency.
- Signed 0x80000000 / 0xFFFFFFFF: `LO` = 0x80000000, `HI` = 0. This falls out of magnitude arithmetic with 32-bit wrap.
- `HI`/`LO` hold their old values throughout ITER; they change only in FIX or on MT ops.

## Timing

- `Start` accepted at edge k. `Busy`=1 from after edge k through edge k+ITER+1, which is 33 cycles for ITER=32.
- `HI`, `LO` and `Done`=1 are all updated at edge k+ITER+1. `Done` is high for exactly one cycle and `Busy` drops in that same cycle.
- A new `Start` is accepted in the cycle `Done`=1, so back-to-back operations have a 34-cycle period.
- MT ops: result is visible the cycle after the accepting edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure

- Package `muldiv_pkg`:
  - Op codes `OP_MULT`, `OP_DIV`, `OP_MTHI`, `OP_MTLO`.
  - State encoding `ST_IDLE`, `ST_ITER`, `ST_FIX`.
  - `DIV0_QUOT` = 32'hFFFFFFFF.
- Sub-module `cond_negate`: parameterised width, outputs `neg ? -x : x`. Instantiated for operand magnitude (32-bit ×2), product (64-bit), quotient and remainder (32-bit).

## Test plan

- MULTU: 0xFFFFFFFF × 0xFFFFFFFF, `Signed`=0 → `HI`=0xFFFFFFFE, `LO`=0x00000001. `Done` is exactly 33 cycles after `Start`, and `Busy` is high 33 cycles.
- MULT: -3 × 7, `Signed`=1 → `HI`=0xFFFFFFFF, `LO`=0xFFFFFFEB. Also 0x80000000 × 0x80000000 → `HI`=0x40000000, `LO`=0.
- DIV: -7 / 2, `Signed`=1 → `LO`=0xFFFFFFFD, `HI`=0xFFFFFFFF. DIVU 100/7 → `LO`=14, `HI`=2.
- Edge cases:
  - 0x1234 / 0 (signed and unsigned) → `LO`=0xFFFFFFFF, `HI`=0x1234.
  - Signed 0x80000000 / -1 → `LO`=0x80000000, `HI`=0.
- Busy-time control:
  - MTHI 0xAAAA5555 in IDLE → `HI` updated next cycle, no `Done`.
  - `Start` of MTLO or MULT during `Busy` → ignored; `LO` and result unaffected.
- Reset and back-to-back:
  - Assert `reset` low at cycle 10 of a DIV → `Busy`=0 and `HI`=`LO`=0 immediately. A following MULT 5×6 completes normally with `LO`=30.
  - Back-to-back `Start` in the `Done` cycle is accepted.
